sprite_ram_loader: RTL
======================

# sprite_ram_loader

Write-side client for the dual-address sprite RAM. It accepts a byte stream from the host link over a valid/ready handshake and unpacks two 12-bit RGB pixels from every three bytes. It then drives the RAM write port (`we`/`addr_w`/`din`), so a sprite image can be replaced at run time without re-synthesising the power-up image. It sits between the host byte receiver and the sprite RAM; the RAM's read port continues to serve the pixel pipeline untouched.

## Interface
- `DATA_WIDTH`, 12: pixel width. Only 12 is supported; elaboration fails on any other value.
- `ADDR_WIDTH`, 12: RAM address bits.
- `PIX_COUNT`, 2**ADDR_WIDTH: pixels per load. Must be even, ≥2, ≤2**ADDR_WIDTH; elaboration fails otherwise.
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a load; honoured only in IDLE.
- `s_data`  in  8: stream byte.
- `s_valid`  in  1: `s_data` valid.
- `s_ready`  out  1: loader accepts a byte this cycle.
- `we`  out  1: RAM write enable (one-cycle pulses).
- `addr_w`  out  ADDR_WIDTH: RAM write address.
- `din`  out  DATA_WIDTH: RAM write data.
- `busy`  out  1: load in progress.
- `done`  out  1: one-cycle pulse at load completion.
- `err`  out  1: checksum mismatch flag (see Configuration).

## Operation
- States:
  - IDLE: `s_ready` = 0.
  - GET0, GET1, GET2: `s_ready` = 1.
  - GETCK: present only with the macro; `s_ready` = 1.
- A byte is accepted on any cycle with `s_valid && s_ready`. Cycles without acceptance leave all state unchanged.
- IDLE + `start` → GET0. This clears the pixel index and `err`.
- Packing: byte0 = p0[11:4]; byte1 = {p0[3:0], p1[11:8]}; byte2 = p1[7:0].
- GET0 on accept: latch byte0 → GET1.
- GET1 on accept:
  - Write p0 = {byte0, byte1[7:4]} at the index.
  - Latch byte1[3:0] and increment the index → GET2.
- GET2 on accept:
  - Write p1 = {byte1[3:0], byte2} at the index, then increment the index.
  - If the written index is PIX_COUNT-1 → IDLE (or GETCK with the macro) and pulse `done` (done deferred with the macro).
  - Otherwise → GET0.
- Total bytes per load: 3*PIX_COUNT/2 (6144 at defaults).
- Index width is ADDR_WIDTH and never wraps within a load; termination is by compare, not overflow.
- `start` while busy is ignored. `s_valid` in IDLE is never accepted.
- RAM write port never back-pressures, so `s_ready` depends only on state.
- Reset mid-load: immediate return to IDLE with all outputs cleared. Pixels already written stay in RAM; there is no rollback.

## Timing
- Reset values: `s_ready`=0, `we`=0, `addr_w`=0, `din`=0, `busy`=0, `done`=0, `err`=0.
- `we`, `addr_w`, `din`, `done` are registered. Each RAM write appears the cycle after the accepting edge of byte1 or byte2.
- `s_ready` and `busy` are decoded from the state register (busy = state≠IDLE). They go high the cycle after `start` is sampled.
- Without the macro, `done` pulses in the same cycle as the final `we`; `busy` falls on that cycle.
- Peak throughput: one byte per cycle, i.e. two pixels per three cycles.
- `addr_w`/`din` hold their last values between writes; only `we` qualifies them.

## Configuration
- `SPRITE_LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum of all pixel bytes is kept, cleared on `start`.
  - After the last pixel the FSM enters GETCK and accepts one extra byte.
  - If (sum + byte) mod 256 ≠ 0, `err` is set. `err` stays set until the next `start` or reset.
  - `done` pulses the cycle after the checksum byte is accepted.
  - Pixel writes occur regardless of checksum outcome.
- Undefined: no GETCK state, no sum register, `err` tied to 0.

## Structure
- Shared package `sprite_pkg`: state enum, `BYTES_PER_PAIR`=3, pixel packing field positions. The RAM and any later sprite blocks reuse these.
- One natural sub-module: `pixel_unpack`. It holds the byte latches and forms p0/p1 from the byte phase. The FSM, index and checksum stay in `sprite_ram_loader`.

## Test plan
- Full load at defaults, continuous `s_valid`:
  - Stimulus: bytes AB,CD,EF repeated.
  - Expected: 4096 writes alternating din=ABC, DEF.
  - `addr_w` runs 0..4095 in order.
  - `done` pulses once, aligned with the write to 4095.
  - 6144 bytes are accepted in 6144 cycles.
- Random `s_valid` gaps:
  - Expected: same RAM contents as with continuous valid.
  - No `we` on cycles without a preceding accept.
- `start` pulsed mid-load, and `s_valid` held high in IDLE:
  - Expected: no index reset.
  - No byte accepted while `s_ready`=0.
- `reset` asserted after 100 bytes:
  - Expected: next cycle all outputs are at reset values; 66 pixels written.
  - A fresh `start` reloads from `addr_w`=0.
- `PIX_COUNT`=2, bytes 12,34,56:
  - Expected: writes addr0=123, addr1=456.
  - `done` pulses once; `busy` clears.
- With the macro:
  - PIX_COUNT=2, bytes 12,34,56 plus trailer 64 (sum 0x9C+0x64=0x100): `err`=0, `done` pulses after the trailer.
  - Same load with trailer 00: `err`=1, held until the next `start`.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite types: loader FSM states and 12-bit pixel packing
package sprite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET0,
    ST_GET1,
    ST_GET2,
    ST_GETCK
  } state_e;

  localparam int BYTES_PER_PAIR = 3;
  localparam int PIX_W          = 12;
  // byte1 is split: high nibble closes p0, low nibble opens p1
  localparam int NIB_W          = 4;

  function automatic logic [PIX_W-1:0] pack_p0(input logic [7:0] b0, input logic [7:0] b1);
    return {b0, b1[7:NIB_W]};
  endfunction

  function automatic logic [PIX_W-1:0] pack_p1(input logic [NIB_W-1:0] nib, input logic [7:0] b2);
    return {nib, b2};
  endfunction

endpackage

// File: rtl/pixel_unpack.sv
// rtl/pixel_unpack.sv - byte latches that turn a 3-byte group into two 12-bit pixels
module pixel_unpack
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_data,
  input  logic             lat_b0,
  input  logic             lat_b1,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1
);

  logic [7:0]       b0_q, b0_d;
  logic [NIB_W-1:0] nib_q, nib_d;

  always_comb begin
    b0_d  = b0_q;
    nib_d = nib_q;
    if (lat_b0) b0_d = s_data;
    if (lat_b1) nib_d = s_data[NIB_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b0_q  <= '0;
      nib_q <= '0;
    end else begin
      b0_q  <= b0_d;
      nib_q <= nib_d;
    end
  end

  // the byte currently on s_data completes whichever pixel its phase owns
  assign p0 = pack_p0(b0_q, s_data);
  assign p1 = pack_p1(nib_q, s_data);

endmodule

// File: rtl/sprite_ram_loader.sv
// rtl/sprite_ram_loader.sv - host byte stream to sprite RAM write-port loader
// Optional trailer checksum byte when SPRITE_LOADER_CHECKSUM_EN is defined.
module sprite_ram_loader
  import sprite_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int PIX_COUNT  = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  if (DATA_WIDTH != PIX_W) begin : g_bad_width
    $error("sprite_ram_loader: DATA_WIDTH must be 12");
  end
  if (PIX_COUNT < 2 || (PIX_COUNT % 2) != 0 || PIX_COUNT > 2**ADDR_WIDTH) begin : g_bad_count
    $error("sprite_ram_loader: PIX_COUNT must be even and within 2..2**ADDR_WIDTH");
  end
  if (int'(ST_GET2) - int'(ST_GET0) + 1 != BYTES_PER_PAIR) begin : g_bad_phases
    $error("sprite_ram_loader: byte phase states do not match BYTES_PER_PAIR");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(PIX_COUNT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  last_pair;
  logic [PIX_W-1:0]      p0, p1;

  assign accept    = s_valid && s_ready;
  assign last_pair = (idx_q == LAST_IDX);

  pixel_unpack u_unpack (
    .clk    (clk),
    .reset  (reset),
    .s_data (s_data),
    .lat_b0 (accept && state_q == ST_GET0),
    .lat_b1 (accept && state_q == ST_GET1),
    .p0     (p0),
    .p1     (p1)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_GET0;
      ST_GET0: if (accept) state_d = ST_GET1;
      ST_GET1: if (accept) state_d = ST_GET2;
      ST_GET2: begin
        if (accept) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
          state_d = last_pair ? ST_GETCK : ST_GET0;
`else
          state_d = last_pair ? ST_IDLE : ST_GET0;
`endif
        end
      end
`ifdef SPRITE_LOADER_CHECKSUM_EN
      ST_GETCK: if (accept) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    s_ready = 1'b0;
    case (state_q)
      ST_GET0, ST_GET1, ST_GET2: s_ready = 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      ST_GETCK:                  s_ready = 1'b1;
`endif
      default:                   s_ready = 1'b0;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    din_d  = din_q;
    we_d   = 1'b0;
    done_d = 1'b0;
    if (state_q == ST_IDLE && start) idx_d = '0;
    if (accept) begin
      case (state_q)
        ST_GET1: begin
          we_d   = 1'b1;
          addr_d = idx_q;
          din_d  = p0;
          idx_d  = idx_q + ADDR_WIDTH'(1);
        end
        ST_GET2: begin
          we_d   = 1'b1;
          addr_d = idx_q;
          din_d  = p1;
          idx_d  = idx_q + ADDR_WIDTH'(1);
`ifndef SPRITE_LOADER_CHECKSUM_EN
          done_d = last_pair;
`endif
        end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        ST_GETCK: done_d = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      we_q   <= we_d;
      done_q <= done_d;
    end
  end

  assign we     = we_q;
  assign addr_w = addr_q;
  assign din    = din_q;
  assign done   = done_q;

`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] ck_sum;
  logic       err_q, err_d;

  assign ck_sum = sum_q + s_data;

  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (state_q == ST_IDLE && start) begin
      sum_d = '0;
      err_d = 1'b0;
    end else if (accept) begin
      if (state_q == ST_GETCK) begin
        if (ck_sum != 8'd0) err_d = 1'b1;
      end else begin
        sum_d = ck_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
